// File: rtl/seg7_scan_to_bcd.sv
// Decodes scanned 7-segment patterns back to BCD, debounces each digit and
// publishes one multi-digit frame per distinct stable set over a valid/ready handshake.
module seg7_scan_to_bcd #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned STABLE_CNT = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sample_en,
    input  logic [6:0]                seg_in,
    input  logic [NUM_DIGITS-1:0]     dig_sel,
    output logic [4*NUM_DIGITS-1:0]   bcd_out,
    output logic [NUM_DIGITS-1:0]     blank_out,
    output logic                      err_out,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam int unsigned CNT_W = $clog2(STABLE_CNT + 1);
    localparam int unsigned BCD_W = 4 * NUM_DIGITS;
    localparam int unsigned TRK_W = 6;

    typedef enum logic {
        S_COLLECT,
        S_HOLD
    } state_t;

    // Pattern -> {code[3:0], blank, illegal}
    function automatic logic [TRK_W-1:0] decode(input logic [6:0] seg);
        logic [TRK_W-1:0] res;
        case (seg)
            7'b1111110: res = {4'h0, 1'b0, 1'b0};
            7'b0110000: res = {4'h1, 1'b0, 1'b0};
            7'b1101101: res = {4'h2, 1'b0, 1'b0};
            7'b1111001: res = {4'h3, 1'b0, 1'b0};
            7'b0110011: res = {4'h4, 1'b0, 1'b0};
            7'b1011011: res = {4'h5, 1'b0, 1'b0};
            7'b1011111: res = {4'h6, 1'b0, 1'b0};
            7'b1110000: res = {4'h7, 1'b0, 1'b0};
            7'b1111111: res = {4'h8, 1'b0, 1'b0};
            7'b1111011: res = {4'h9, 1'b0, 1'b0};
            7'b0000000: res = {4'h0, 1'b1, 1'b0};
            default:    res = {4'hF, 1'b0, 1'b1};
        endcase
        return res;
    endfunction

    logic [TRK_W-1:0]  w_dec;
    logic              w_onehot;
    logic              w_accept;
    logic              w_all_stable;
    logic              w_any_illegal;
    logic              w_set_differs;
    logic [BCD_W-1:0]  w_set_bcd;
    logic [NUM_DIGITS-1:0] w_set_blank;

    logic [TRK_W-1:0]  r_trk [NUM_DIGITS];
    logic [CNT_W-1:0]  r_cnt [NUM_DIGITS];
    state_t            r_state;
    logic              r_sel_err;
    logic              r_published;
    logic [BCD_W-1:0]  r_last_bcd;
    logic [NUM_DIGITS-1:0] r_last_blank;

    assign w_dec    = decode(seg_in);
    assign w_onehot = $onehot(dig_sel);
    assign w_accept = sample_en & w_onehot;

    // Per-digit run trackers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_trk[i] <= '0;
                r_cnt[i] <= '0;
            end
        end else if (w_accept) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (dig_sel[i]) begin
                    if (r_trk[i] == w_dec) begin
                        if (r_cnt[i] != CNT_W'(STABLE_CNT))
                            r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                    end else begin
                        r_trk[i] <= w_dec;
                        r_cnt[i] <= CNT_W'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        w_all_stable  = 1'b1;
        w_any_illegal = 1'b0;
        w_set_bcd     = '0;
        w_set_blank   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_cnt[i] != CNT_W'(STABLE_CNT))
                w_all_stable = 1'b0;
            w_set_bcd[4*i +: 4] = r_trk[i][5:2];
            w_set_blank[i]      = r_trk[i][1];
            w_any_illegal       = w_any_illegal | r_trk[i][0];
        end
    end

    // Illegal digits are the only F nibbles and blanks carry their own bit, so {bcd, blank} identifies a set
    assign w_set_differs = !r_published || (w_set_bcd != r_last_bcd) || (w_set_blank != r_last_blank);

    // Frame publisher; a new bad select wins over the clear on handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_COLLECT;
            out_valid    <= 1'b0;
            bcd_out      <= '0;
            blank_out    <= '0;
            err_out      <= 1'b0;
            r_sel_err    <= 1'b0;
            r_published  <= 1'b0;
            r_last_bcd   <= '0;
            r_last_blank <= '0;
        end else begin
            if (sample_en && !w_onehot)
                r_sel_err <= 1'b1;
            else if (out_valid && out_ready)
                r_sel_err <= 1'b0;

            case (r_state)
                S_COLLECT: begin
                    if (w_all_stable && w_set_differs) begin
                        bcd_out   <= w_set_bcd;
                        blank_out <= w_set_blank;
                        err_out   <= w_any_illegal | r_sel_err;
                        out_valid <= 1'b1;
                        r_state   <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid    <= 1'b0;
                        r_published  <= 1'b1;
                        r_last_bcd   <= bcd_out;
                        r_last_blank <= blank_out;
                        r_state      <= S_COLLECT;
                    end
                end
                default: r_state <= S_COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_scan_to_bcd.sv
// Scoreboard bench for seg7_scan_to_bcd: directed scans push expected frames,
// a negedge monitor compares every presented frame against the queue head.
module tb_seg7_scan_to_bcd;

    localparam int unsigned ND = 4;

    logic            clk;
    logic            rst;
    logic            sample_en;
    logic [6:0]      seg_in;
    logic [ND-1:0]   dig_sel;
    logic [4*ND-1:0] bcd_out;
    logic [ND-1:0]   blank_out;
    logic            err_out;
    logic            out_valid;
    logic            out_ready;

    logic [20:0]     exp_q [$];
    logic            chk_zero;
    logic            chk_drain;
    int              checks;
    int              errors;

    seg7_scan_to_bcd #(.NUM_DIGITS(ND), .STABLE_CNT(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .sample_en (sample_en),
        .seg_in    (seg_in),
        .dig_sel   (dig_sel),
        .bcd_out   (bcd_out),
        .blank_out (blank_out),
        .err_out   (err_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // 0..9 digits, 10 = blank, 11 = illegal pattern
    function automatic logic [6:0] seg_of(input int v);
        case (v)
            0:  return 7'b1111110;
            1:  return 7'b0110000;
            2:  return 7'b1101101;
            3:  return 7'b1111001;
            4:  return 7'b0110011;
            5:  return 7'b1011011;
            6:  return 7'b1011111;
            7:  return 7'b1110000;
            8:  return 7'b1111111;
            9:  return 7'b1111011;
            10: return 7'b0000000;
            default: return 7'b1000000;
        endcase
    endfunction

    // Monitor: sole owner of the check/error counters
    always @(negedge clk) begin
        if (chk_zero) begin
            checks++;
            if ({bcd_out, blank_out, err_out, out_valid} !== 22'h0) begin
                errors++;
                $display("FAIL reset_outputs got bcd=%h blank=%b err=%b valid=%b want all 0",
                         bcd_out, blank_out, err_out, out_valid);
            end
        end
        if (chk_drain) begin
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL frame_missing got %0d frames pending want 0, head=%h",
                         exp_q.size(), exp_q[0]);
            end
        end
        if (rst) begin
            exp_q.delete();
        end else if (out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_frame got bcd=%h blank=%b err=%b want no frame",
                         bcd_out, blank_out, err_out);
            end else begin
                if ({bcd_out, blank_out, err_out} !== exp_q[0]) begin
                    errors++;
                    $display("FAIL frame got bcd=%h blank=%b err=%b want bcd=%h blank=%b err=%b",
                             bcd_out, blank_out, err_out,
                             exp_q[0][20:5], exp_q[0][4:1], exp_q[0][0]);
                end
                if (out_ready)
                    void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic sample(input int d, input int v);
        sample_en = 1'b1;
        seg_in    = seg_of(v);
        dig_sel   = ND'(1) << d;
        tick();
        sample_en = 1'b0;
    endtask

    task automatic scan4(input int v0, input int v1, input int v2, input int v3, input int rounds);
        for (int r = 0; r < rounds; r++) begin
            sample(0, v0);
            sample(1, v1);
            sample(2, v2);
            sample(3, v3);
        end
    endtask

    task automatic expect_frame(input logic [15:0] b, input logic [3:0] bl, input logic e);
        exp_q.push_back({b, bl, e});
    endtask

    task automatic drain_check();
        chk_drain = 1'b1;
        tick();
        chk_drain = 1'b0;
    endtask

    task automatic zero_check();
        chk_zero = 1'b1;
        tick();
        chk_zero = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        chk_zero  = 1'b0;
        chk_drain = 1'b0;
        rst       = 1'b1;
        sample_en = 1'b0;
        seg_in    = '0;
        dig_sel   = '0;
        out_ready = 1'b1;
        idle(3);
        zero_check();
        rst = 1'b0;
        idle(2);

        // Basic frame 4321
        expect_frame(16'h4321, 4'h0, 1'b0);
        scan4(1, 2, 3, 4, 3);
        idle(8);
        drain_check();

        // Identical set must not republish
        scan4(1, 2, 3, 4, 5);
        idle(8);
        drain_check();

        // Digit 0 changes 1 -> 2
        expect_frame(16'h4322, 4'h0, 1'b0);
        sample(0, 1);
        sample(0, 1);
        for (int i = 0; i < 3; i++) sample(0, 2);
        idle(8);
        drain_check();

        // Illegal digit 2, then blank digit 3
        expect_frame(16'h4F22, 4'h0, 1'b1);
        for (int i = 0; i < 3; i++) sample(2, 11);
        idle(8);
        drain_check();
        expect_frame(16'h0F22, 4'h8, 1'b1);
        for (int i = 0; i < 3; i++) sample(3, 10);
        idle(8);
        drain_check();

        // Back-pressure: first frame held for 20 cycles, then 8765 follows
        out_ready = 1'b0;
        expect_frame(16'h0322, 4'h8, 1'b0);
        expect_frame(16'h8765, 4'h0, 1'b0);
        for (int i = 0; i < 3; i++) sample(2, 3);
        scan4(5, 6, 7, 8, 3);
        idle(5);
        out_ready = 1'b1;
        idle(8);
        drain_check();

        // Non-one-hot select flags the next frame
        sample_en = 1'b1;
        seg_in    = seg_of(9);
        dig_sel   = 4'b0011;
        tick();
        sample_en = 1'b0;
        expect_frame(16'h8769, 4'h0, 1'b1);
        for (int i = 0; i < 3; i++) sample(0, 9);
        idle(8);
        drain_check();

        // Reset while a frame is held drops it
        out_ready = 1'b0;
        expect_frame(16'h8760, 4'h0, 1'b0);
        for (int i = 0; i < 3; i++) sample(0, 0);
        idle(4);
        rst = 1'b1;
        tick();
        zero_check();
        rst = 1'b0;
        out_ready = 1'b1;
        idle(10);
        drain_check();

        // Publishing resumes from a clean state
        expect_frame(16'h8760, 4'h0, 1'b0);
        scan4(0, 6, 7, 8, 3);
        idle(8);
        drain_check();

        idle(3);
        @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
